// File: rtl/beam_scaler_pkg.sv
// Shared widths, types and helpers for the per-beam trigger rate scaler.
package beam_scaler_pkg;

  localparam int unsigned NBEAMS_DEF    = 46;
  localparam int unsigned CNTBITS_DEF   = 16;
  localparam int unsigned GATE_BITS_DEF = 32;
  localparam int unsigned SEQ_BITS      = 8;

  typedef logic [CNTBITS_DEF-1:0]   count_t;
  typedef logic [GATE_BITS_DEF-1:0] gate_t;
  typedef logic [SEQ_BITS-1:0]      seq_t;

  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width-generic saturating increment (w <= 32); v is zero-extended by the caller.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc,
                                          input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (inc && (v != max_v)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/beam_scaler_cell.sv
// One beam: rising-edge detect, saturating live count and snapshot register.
module beam_scaler_cell
  import beam_scaler_pkg::*;
#(
  parameter int unsigned CNTBITS = CNTBITS_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               trigger_i,
  input  logic               clear_i,
  input  logic               snap_i,
  output logic [CNTBITS-1:0] snapshot_o
);

  logic               trig_q;
  logic               event_w;
  logic [CNTBITS-1:0] live;
  logic [CNTBITS-1:0] live_inc;

  always_comb begin
    event_w  = trigger_i & ~trig_q;
    live_inc = CNTBITS'(sat_inc(32'(live), event_w, CNTBITS));
  end

  // History resets high so a trigger held through reset release is not an edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trig_q     <= 1'b1;
      live       <= '0;
      snapshot_o <= '0;
    end else begin
      trig_q <= trigger_i;
      if (clear_i) begin
        live <= '0;
      end else if (snap_i) begin
        snapshot_o <= live_inc;
        live       <= '0;
      end else begin
        live <= live_inc;
      end
    end
  end

endmodule

// File: rtl/beam_trigger_scaler.sv
// Per-beam trigger rate scaler: gate timer, snapshot sequencing and pipelined indexed read port.
module beam_trigger_scaler
  import beam_scaler_pkg::*;
#(
  parameter  int unsigned NBEAMS       = NBEAMS_DEF,
  parameter  int unsigned CNTBITS      = CNTBITS_DEF,
  parameter  int unsigned GATE_BITS    = GATE_BITS_DEF,
  parameter  int unsigned GATE_DEFAULT = 1000,
  localparam int unsigned IDX_BITS     = idx_bits(NBEAMS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NBEAMS-1:0]    trigger_i,
  input  logic [GATE_BITS-1:0] gate_len_i,
  input  logic                 gate_len_wr_i,
  input  logic [IDX_BITS-1:0]  scal_idx_i,
  input  logic                 scal_rd_i,
  output logic [CNTBITS-1:0]   scal_dat_o,
  output logic                 scal_valid_o,
  output logic                 window_done_o,
  output seq_t                 seq_o
);

  logic [GATE_BITS-1:0] gate_len;
  logic [GATE_BITS-1:0] timer;
  logic                 terminal;
  logic                 snap_now;

  logic [CNTBITS-1:0]   snap_arr [NBEAMS];
  logic [IDX_BITS-1:0]  idx_q;
  logic                 rd_q;
  logic [CNTBITS-1:0]   rd_mux;

  // A gate length write discards a coincident window close.
  always_comb begin
    terminal = (gate_len != '0) && (timer == gate_len - GATE_BITS'(1));
    snap_now = terminal & ~gate_len_wr_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gate_len      <= GATE_BITS'(GATE_DEFAULT);
      timer         <= '0;
      seq_o         <= '0;
      window_done_o <= 1'b0;
    end else begin
      window_done_o <= 1'b0;
      if (gate_len_wr_i) begin
        gate_len <= gate_len_i;
        timer    <= '0;
      end else if (terminal) begin
        timer         <= '0;
        seq_o         <= seq_o + seq_t'(1);
        window_done_o <= 1'b1;
      end else if (gate_len != '0) begin
        timer <= timer + GATE_BITS'(1);
      end
    end
  end

  for (genvar b = 0; b < NBEAMS; b++) begin : g_cell
    beam_scaler_cell #(
      .CNTBITS (CNTBITS)
    ) u_cell (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .trigger_i  (trigger_i[b]),
      .clear_i    (gate_len_wr_i),
      .snap_i     (snap_now),
      .snapshot_o (snap_arr[b])
    );
  end

  // Out-of-range indices match no beam and read back as zero.
  always_comb begin
    rd_mux = '0;
    for (int unsigned b = 0; b < NBEAMS; b++) begin
      if (idx_q == IDX_BITS'(b)) rd_mux = snap_arr[b];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q        <= '0;
      rd_q         <= 1'b0;
      scal_dat_o   <= '0;
      scal_valid_o <= 1'b0;
    end else begin
      idx_q        <= scal_idx_i;
      rd_q         <= scal_rd_i;
      scal_valid_o <= rd_q;
      if (rd_q) scal_dat_o <= rd_mux;
    end
  end

endmodule

// File: tb/tb_beam_trigger_scaler.sv
// Directed/random bench for beam_trigger_scaler against a per-cycle behavioural model.
module tb_beam_trigger_scaler;
  import beam_scaler_pkg::*;

  localparam int NB   = 46;
  localparam int CB   = 8;
  localparam int CMAX = 255;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [NB-1:0] trig;
  logic [31:0]   gl;
  logic          wr;
  logic [5:0]    idx;
  logic          rd;
  logic [CB-1:0] scal_dat_o;
  logic          scal_valid_o;
  logic          window_done_o;
  seq_t          seq_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  beam_trigger_scaler #(
    .NBEAMS       (NB),
    .CNTBITS      (CB),
    .GATE_BITS    (32),
    .GATE_DEFAULT (1000)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .trigger_i     (trig),
    .gate_len_i    (gl),
    .gate_len_wr_i (wr),
    .scal_idx_i    (idx),
    .scal_rd_i     (rd),
    .scal_dat_o    (scal_dat_o),
    .scal_valid_o  (scal_valid_o),
    .window_done_o (window_done_o),
    .seq_o         (seq_o)
  );

  // Reference model state: counts as plain integers.
  int m_live [NB];
  int m_snap [NB];
  bit m_prev [NB];
  int m_timer, m_gate, m_seq, m_ri, m_od;
  bit m_wd, m_rv, m_ov;

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_edge();
    int ev [NB];
    if (rst_i) begin
      for (int b = 0; b < NB; b++) begin
        m_live[b] = 0; m_snap[b] = 0; m_prev[b] = 1'b1;
      end
      m_timer = 0; m_gate = 1000; m_seq = 0;
      m_wd = 0; m_rv = 0; m_ov = 0; m_ri = 0; m_od = 0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        ev[b]     = (trig[b] && !m_prev[b]) ? 1 : 0;
        m_prev[b] = trig[b];
      end
      m_ov = m_rv;
      if (m_rv) m_od = (m_ri < NB) ? m_snap[m_ri] : 0;
      m_rv = rd;
      m_ri = int'(idx);
      m_wd = 0;
      if (wr) begin
        m_gate  = int'(gl);
        m_timer = 0;
        for (int b = 0; b < NB; b++) m_live[b] = 0;
      end else if (m_gate != 0 && m_timer == m_gate - 1) begin
        for (int b = 0; b < NB; b++) begin
          m_snap[b] = sat(m_live[b] + ev[b]);
          m_live[b] = 0;
        end
        m_timer = 0;
        m_seq   = (m_seq + 1) % 256;
        m_wd    = 1;
      end else begin
        for (int b = 0; b < NB; b++) m_live[b] = sat(m_live[b] + ev[b]);
        if (m_gate != 0) m_timer++;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    model_edge();
    #1;
    check("window_done", 32'(window_done_o), 32'(m_wd));
    check("seq", 32'(seq_o), m_seq);
    check("scal_valid", 32'(scal_valid_o), 32'(m_ov));
    check("scal_dat", 32'(scal_dat_o), m_od);
  endtask

  task automatic read_beam(input int i, output int val);
    rd  = 1'b1;
    idx = 6'(i);
    step();
    rd  = 1'b0;
    step();
    val = int'(scal_dat_o);
  endtask

  task automatic write_gate(input int len);
    wr = 1'b1;
    gl = len;
    step();
    wr = 1'b0;
  endtask

  initial begin
    int v, n, s0, vc;
    rst_i = 1'b1; trig = '0; gl = '0; wr = 1'b0; idx = '0; rd = 1'b0;
    step();
    step();
    check("reset_valid", 32'(scal_valid_o), 0);
    check("reset_seq", 32'(seq_o), 0);
    rst_i = 1'b0;

    // Default gate length after reset.
    n = 0;
    do begin step(); n++; end while (!window_done_o && n < 1100);
    check("default_gate_len", n, 1000);

    // Periodic pulses on beam 0, gate 100.
    write_gate(100);
    s0 = int'(seq_o);
    vc = 0;
    for (int k = 0; k < 300; k++) begin
      trig[0] = (k % 10 == 0);
      step();
      if (window_done_o) vc++;
    end
    trig = '0;
    check("t1_seq_delta", 32'(seq_o), (s0 + 3) % 256);
    check("t1_window_pulses", vc, 3);
    read_beam(0, v);
    check("t1_snap0", v, 10);

    // Held trigger counts once, then zero.
    write_gate(100);
    trig[5] = 1'b1;
    repeat (100) step();
    read_beam(5, v);
    check("t2_held_first", v, 1);
    repeat (98) step();
    read_beam(5, v);
    check("t2_held_next", v, 0);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    repeat (1000) step();
    read_beam(5, v);
    check("t2_held_through_reset", v, 0);

    // Saturation with toggling trigger.
    trig = '0;
    write_gate(1000);
    for (int k = 0; k < 1000; k++) begin
      trig[3] = (k % 2 == 0);
      step();
    end
    trig = '0;
    read_beam(3, v);
    check("t3_saturated", v, 255);

    // Edge on terminal cycle.
    write_gate(10);
    repeat (9) step();
    trig[1] = 1'b1;
    step();
    check("t4_wd_terminal", 32'(window_done_o), 1);
    trig[1] = 1'b0;
    read_beam(1, v);
    check("t4_terminal_edge", v, 1);
    repeat (8) step();
    read_beam(1, v);
    check("t4_next_window", v, 0);

    // Gate write on terminal cycle discards the window.
    n = 0;
    while (m_timer != m_gate - 1 && n < 20) begin step(); n++; end
    check("t4_reach_terminal", m_timer, m_gate - 1);
    s0 = int'(seq_o);
    write_gate(10);
    check("t4_wr_no_wd", 32'(window_done_o), 0);
    check("t4_wr_seq_same", 32'(seq_o), s0);
    n = 0;
    do begin step(); n++; end while (!window_done_o && n < 20);
    check("t4_restart_len", n, 10);

    // Random triggers on all beams, then back-to-back read burst.
    write_gate(50);
    repeat (400) begin
      trig = NB'({$urandom, $urandom});
      step();
    end
    vc = 0;
    for (int i = 0; i < 48; i++) begin
      idx  = (i < 46) ? 6'(i) : ((i == 46) ? 6'd46 : 6'd63);
      rd   = 1'b1;
      trig = NB'({$urandom, $urandom});
      step();
      if (scal_valid_o) vc++;
      if (i == 47) check("t5_oob46", 32'(scal_dat_o), 0);
    end
    rd = 1'b0;
    step();
    if (scal_valid_o) vc++;
    check("t5_oob63", 32'(scal_dat_o), 0);
    step();
    if (scal_valid_o) vc++;
    check("t5_valid_count", vc, 48);

    // Reset during read burst and mid-window.
    write_gate(50);
    repeat (20) begin
      trig = NB'({$urandom, $urandom});
      step();
    end
    rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idx = 6'($urandom_range(0, 45));
      step();
    end
    rst_i = 1'b1;
    step();
    check("t6_valid", 32'(scal_valid_o), 0);
    check("t6_dat", 32'(scal_dat_o), 0);
    check("t6_seq", 32'(seq_o), 0);
    check("t6_wd", 32'(window_done_o), 0);
    rst_i = 1'b0;
    rd    = 1'b0;
    trig  = '0;
    step();
    check("t6_valid_after", 32'(scal_valid_o), 0);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
